// File: rtl/tc7seg_pkg.sv
// Shared constants, state type and sizing helper for the two's-complement
// to 7-segment converter. Segment vectors are active-low, bit i = segment i.
package tc7seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  // Number of decimal digits needed for the largest magnitude, 2^(width-1)
  function automatic int req_digits(input int width);
    longint unsigned v;
    int n;
    v = 64'd1 << (width - 1);
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder with blanking.
module bcd_digit_to_7seg
  import tc7seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Decode one digit; codes 10-15 and a blank request give an unlit display
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_DIGIT[0];
        4'd1:    seg = SEG_DIGIT[1];
        4'd2:    seg = SEG_DIGIT[2];
        4'd3:    seg = SEG_DIGIT[3];
        4'd4:    seg = SEG_DIGIT[4];
        4'd5:    seg = SEG_DIGIT[5];
        4'd6:    seg = SEG_DIGIT[6];
        4'd7:    seg = SEG_DIGIT[7];
        4'd8:    seg = SEG_DIGIT[8];
        4'd9:    seg = SEG_DIGIT[9];
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/tc_to_7seg_seq.sv
// Sequential two's-complement to multi-digit 7-segment converter.
// A start in IDLE captures sign and magnitude, WIDTH double-dabble steps
// build the BCD digits, and an UPDATE cycle registers the decoded displays
// while pulsing done. Displays hold the previous result in between.
module tc_to_7seg_seq
  import tc7seg_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter bit LZ_BLANK = 1'b1
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [6:0]            sign_seg,
  output logic [7*DIGITS-1:0]   mag_seg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  generate
    if (WIDTH < 2) begin : g_width_too_small
      $error("tc_to_7seg_seq: WIDTH must be at least 2");
    end
    if (DIGITS < req_digits(WIDTH)) begin : g_digits_too_few
      $error("tc_to_7seg_seq: DIGITS too small to show 2^(WIDTH-1)");
    end
  endgenerate

  state_t                  state;
  logic                    sign_p0;
  logic [WIDTH-1:0]        mag_p0;
  logic [BCD_W-1:0]        bcd_p0;
  logic [CNT_W-1:0]        cnt;

  logic [WIDTH-1:0]        abs_value;
  logic [BCD_W-1:0]        bcd_adj;
  logic [DIGITS-1:0]       blank;
  logic [7*DIGITS-1:0]     seg_dec;
  logic [6:0]              sign_dec;

  // Magnitude of the input; the most negative value maps to 2^(WIDTH-1)
  always_comb begin
    abs_value = value;
    if (value[WIDTH-1]) abs_value = ~value + 1'b1;
  end

  // Add-3 correction on every nibble that would overflow when doubled
  always_comb begin
    bcd_adj = bcd_p0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_p0[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_p0[4*d +: 4] + 4'd3;
    end
  end

  // Leading-zero blanking: blank digits above the top nonzero one, never digit 0
  always_comb begin
    logic nz;
    nz    = 1'b0;
    blank = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      nz       = nz | (bcd_p0[4*d +: 4] != 4'd0);
      blank[d] = LZ_BLANK && (d != 0) && !nz;
    end
  end

  // Minus sign only for a nonzero negative magnitude
  always_comb begin
    sign_dec = SEG_BLANK;
    if (sign_p0 && (bcd_p0 != '0)) sign_dec = SEG_MINUS;
  end

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit_to_7seg u_dec (
        .bcd   (bcd_p0[4*g +: 4]),
        .blank (blank[g]),
        .seg   (seg_dec[7*g +: 7])
      );
    end
  endgenerate

  // Control FSM with double-dabble datapath and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sign_p0  <= 1'b0;
      mag_p0   <= '0;
      bcd_p0   <= '0;
      cnt      <= '0;
      sign_seg <= SEG_BLANK;
      mag_seg  <= {DIGITS{SEG_BLANK}};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_p0 <= value[WIDTH-1];
            mag_p0  <= abs_value;
            bcd_p0  <= '0;
            cnt     <= CNT_W'(WIDTH);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_p0 <= {bcd_adj[BCD_W-2:0], mag_p0[WIDTH-1]};
          mag_p0 <= {mag_p0[WIDTH-2:0], 1'b0};
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= UPDATE;
        end
        UPDATE: begin
          sign_seg <= sign_dec;
          mag_seg  <= seg_dec;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_to_7seg_seq.sv
// Bench for tc_to_7seg_seq: three instances (8-bit/3 digits with and without
// leading-zero blanking, 4-bit/1 digit) checked every cycle against an
// arithmetic model of the displayed result and conversion timing.
module tb_tc_to_7seg_seq;

  localparam int NI = 3;
  localparam int IW [NI] = '{8, 8, 4};
  localparam int ID [NI] = '{3, 3, 1};
  localparam int IL [NI] = '{1, 0, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st  [NI];
  logic [7:0]  val [NI];

  logic        busy_o [NI];
  logic        done_o [NI];
  logic [6:0]  sign_o [NI];
  logic [20:0] mag_o  [NI];
  logic [6:0]  mag4;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  tc_to_7seg_seq #(.WIDTH(8), .DIGITS(3), .LZ_BLANK(1'b1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .value(val[0]),
    .busy(busy_o[0]), .done(done_o[0]), .sign_seg(sign_o[0]), .mag_seg(mag_o[0]));

  tc_to_7seg_seq #(.WIDTH(8), .DIGITS(3), .LZ_BLANK(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .value(val[1]),
    .busy(busy_o[1]), .done(done_o[1]), .sign_seg(sign_o[1]), .mag_seg(mag_o[1]));

  tc_to_7seg_seq #(.WIDTH(4), .DIGITS(1), .LZ_BLANK(1'b1)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .value(val[2][3:0]),
    .busy(busy_o[2]), .done(done_o[2]), .sign_seg(sign_o[2]), .mag_seg(mag4));

  assign mag_o[2] = {14'h3FFF, mag4};

  function automatic logic [6:0] seg_of(input int n);
    case (n)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected {sign_seg, mag_seg(21 bits, unused digits blank)} for a value
  function automatic logic [27:0] calc(input int w, input int d, input int lz, input logic [7:0] v);
    int x, a, p;
    logic [6:0]  s;
    logic [20:0] m;
    x = int'(v) & ((1 << w) - 1);
    if (x >= (1 << (w - 1))) x = x - (1 << w);
    a = (x < 0) ? -x : x;
    s = (x < 0) ? 7'b0111111 : 7'b1111111;
    m = '1;
    p = 1;
    for (int i = 0; i < d; i++) begin
      if (i == 0 || lz == 0 || a >= p) m[7*i +: 7] = seg_of((a / p) % 10);
      p = p * 10;
    end
    return {s, m};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a conversion shows its arithmetic result WIDTH+1 edges after an accepted start
  int          m_cnt  [NI];
  logic        m_busy [NI];
  logic        m_done [NI];
  logic [6:0]  m_sign [NI];
  logic [20:0] m_mag  [NI];
  logic [27:0] m_pend [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_cnt[i]  <= 0;
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_sign[i] <= 7'h7F;
        m_mag[i]  <= '1;
        m_pend[i] <= '1;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        m_done[i] <= 1'b0;
        if (m_cnt[i] == 0) begin
          if (st[i]) begin
            m_pend[i] <= calc(IW[i], ID[i], IL[i], val[i]);
            m_cnt[i]  <= IW[i] + 1;
            m_busy[i] <= 1'b1;
          end
        end else begin
          m_cnt[i] <= m_cnt[i] - 1;
          if (m_cnt[i] == 1) begin
            m_done[i] <= 1'b1;
            m_busy[i] <= 1'b0;
            m_sign[i] <= m_pend[i][27:21];
            m_mag[i]  <= m_pend[i][20:0];
          end
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model
  initial begin : cmp
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < NI; i++) begin
          check($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(m_busy[i]));
          check($sformatf("done[%0d]", i), 32'(done_o[i]), 32'(m_done[i]));
          check($sformatf("sign[%0d]", i), 32'(sign_o[i]), 32'(m_sign[i]));
          check($sformatf("mag[%0d]", i),  32'(mag_o[i]),  32'(m_mag[i]));
        end
      end
    end
  end

  // Start one conversion and check latency, busy length and literal displays
  task automatic run_conv(input int i, input logic [7:0] v, input logic [6:0] es, input logic [20:0] em);
    int n, nb;
    @(negedge clk);
    st[i]  = 1'b1;
    val[i] = v;
    n  = 0;
    nb = 0;
    while (n < 30) begin
      @(negedge clk);
      st[i] = 1'b0;
      n++;
      if (busy_o[i]) nb++;
      if (done_o[i]) break;
    end
    check($sformatf("latency[%0d] v=%0h", i, v), 32'(n), 32'(IW[i] + 2));
    check($sformatf("busy_len[%0d] v=%0h", i, v), 32'(nb), 32'(IW[i] + 1));
    check($sformatf("sign_lit[%0d] v=%0h", i, v), 32'(sign_o[i]), 32'(es));
    check($sformatf("mag_lit[%0d] v=%0h", i, v), 32'(mag_o[i]), 32'(em));
  endtask

  initial begin
    int ndone;
    for (int i = 0; i < NI; i++) begin
      st[i]  = 1'b0;
      val[i] = 8'h00;
    end

    // Model pinned against hand-computed displays
    check("model -123", calc(8, 3, 1, 8'h85), {7'b0111111, 7'b1111001, 7'b0100100, 7'b0110000});
    check("model 0 lz", calc(8, 3, 1, 8'h00), {7'h7F, 7'h7F, 7'h7F, 7'b1000000});
    check("model 0 nz", calc(8, 3, 0, 8'h00), {7'h7F, 7'b1000000, 7'b1000000, 7'b1000000});
    check("model -8 w4", calc(4, 1, 1, 8'h08), {7'b0111111, 14'h3FFF, 7'b0000000});

    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset sign", 32'(sign_o[0]), 32'h7F);
    check("reset mag",  32'(mag_o[0]),  32'h1FFFFF);
    rst_n = 1'b1;

    run_conv(0, 8'h85, 7'b0111111, {7'b1111001, 7'b0100100, 7'b0110000});
    run_conv(0, 8'h80, 7'b0111111, {7'b1111001, 7'b0100100, 7'b0000000});
    run_conv(0, 8'h7F, 7'b1111111, {7'b1111001, 7'b0100100, 7'b1111000});
    run_conv(0, 8'h00, 7'b1111111, {7'h7F, 7'h7F, 7'b1000000});
    run_conv(1, 8'h00, 7'b1111111, {7'b1000000, 7'b1000000, 7'b1000000});
    run_conv(2, 8'h08, 7'b0111111, {14'h3FFF, 7'b0000000});

    // Second start while busy is ignored
    @(negedge clk); st[0] = 1'b1; val[0] = 8'h05;
    @(negedge clk); st[0] = 1'b0;
    @(negedge clk); st[0] = 1'b1; val[0] = 8'h0A;
    @(negedge clk); st[0] = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_o[0]) ndone++;
    end
    check("ignored start dones", 32'(ndone), 32'd1);
    check("ignored start mag", 32'(mag_o[0]), 32'({7'h7F, 7'h7F, 7'b0010010}));
    check("ignored start sign", 32'(sign_o[0]), 32'h7F);

    // Asynchronous reset four edges into a conversion aborts it
    @(negedge clk); st[0] = 1'b1; val[0] = 8'h63;
    @(posedge clk);
    @(negedge clk); st[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy_o[0]), 32'd0);
    check("abort done", 32'(done_o[0]), 32'd0);
    check("abort sign", 32'(sign_o[0]), 32'h7F);
    check("abort mag",  32'(mag_o[0]),  32'h1FFFFF);
    check("abort mag nz", 32'(mag_o[1]), 32'h1FFFFF);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_o[0]) ndone++;
    end
    check("abort no done", 32'(ndone), 32'd0);

    // Randomized starts and values, including held-high start and a stray reset
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        st[i]  = ($urandom_range(0, 3) != 0);
        val[i] = 8'($urandom);
      end
      if (c == 700) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) st[i] = 1'b0;
    repeat (12) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
